// File: rtl/div_iter_param.sv
// Radix-2 restoring iterative divider, one op in flight, valid/ready on both sides, flushable.
// Define DIV_ITER_SPECIAL_BYPASS_EN to resolve divide-by-zero and signed overflow at accept.
module div_iter_param #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  output logic             in_ready,
  input  logic             in_valid,
  input  logic             in_sign,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic [TAG_W-1:0] out_tag
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam int unsigned ACC_W = 2 * WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_step;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   diff;
  logic [TAG_W-1:0] tag;
  logic             qs;
  logic             rs;
  logic             accept;
  logic             step_bit;
  logic             a_neg;
  logic             b_neg;
  logic             bypass;
  logic [WIDTH-1:0] bypass_quot;
  logic [WIDTH-1:0] bypass_rem;

  assign a_neg  = in_sign & in_a[WIDTH-1];
  assign b_neg  = in_sign & in_b[WIDTH-1];
  assign a_abs  = a_neg ? WIDTH'(-in_a) : in_a;
  assign b_abs  = b_neg ? WIDTH'(-in_b) : in_b;
  assign accept = (state == IDLE) & in_valid & ~flush;

`ifdef DIV_ITER_SPECIAL_BYPASS_EN
  logic b_zero;
  logic s_ovf;
  assign b_zero      = (in_b == '0);
  assign s_ovf       = in_sign & (in_a == {1'b1, {(WIDTH-1){1'b0}}}) & (in_b == '1);
  assign bypass      = b_zero | s_ovf;
  assign bypass_quot = b_zero ? '1 : in_a;
  assign bypass_rem  = b_zero ? in_a : '0;
`else
  assign bypass      = 1'b0;
  assign bypass_quot = '0;
  assign bypass_rem  = '0;
`endif

  // One restoring step: trial-subtract the divisor from the top of the partial remainder.
  always_comb begin
    diff     = acc[ACC_W-1:WIDTH-1] - {1'b0, b_mag};
    step_bit = ~diff[WIDTH];
    acc_step = {acc[ACC_W-2:0], 1'b0};
    if (step_bit) begin
      acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    end
    q_step = {q[WIDTH-2:0], step_bit};
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = bypass ? HOLD : RUN;
      RUN: begin
        if (flush) begin
          state_nxt = IDLE;
        end else if (cnt == '0) begin
          state_nxt = HOLD;
        end
      end
      HOLD: if (out_ready | flush) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Datapath; result registers load only on the transition into HOLD.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      cnt       <= '0;
      acc       <= '0;
      b_mag     <= '0;
      q         <= '0;
      qs        <= 1'b0;
      rs        <= 1'b0;
      tag       <= '0;
      out_quot  <= '0;
      out_rem   <= '0;
      out_tag   <= '0;
    end else begin
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == HOLD);
      case (state)
        IDLE: begin
          if (accept) begin
            acc   <= {{WIDTH{1'b0}}, a_abs};
            b_mag <= b_abs;
            q     <= '0;
            cnt   <= CNT_W'(WIDTH - 1);
            qs    <= (a_neg ^ b_neg) & (in_b != '0);
            rs    <= a_neg;
            tag   <= in_tag;
            if (bypass) begin
              out_quot <= bypass_quot;
              out_rem  <= bypass_rem;
              out_tag  <= in_tag;
            end
          end
        end
        RUN: begin
          if (!flush) begin
            acc <= acc_step;
            q   <= q_step;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              out_quot <= qs ? WIDTH'(-q_step) : q_step;
              out_rem  <= rs ? WIDTH'(-acc_step[ACC_W-1:WIDTH]) : acc_step[ACC_W-1:WIDTH];
              out_tag  <= tag;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter_param.sv
// Scoreboard bench for div_iter_param (WIDTH=8, TAG_W=2): directed corner cases plus random ops
// checked against an arithmetic reference model.
module tb_div_iter_param;

  localparam int unsigned W  = 8;
  localparam int unsigned TW = 2;
`ifdef DIV_ITER_SPECIAL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clock;
  logic          reset_n;
  logic          flush;
  logic          in_ready;
  logic          in_valid;
  logic          in_sign;
  logic [W-1:0]  in_a;
  logic [W-1:0]  in_b;
  logic [TW-1:0] in_tag;
  logic          out_ready;
  logic          out_valid;
  logic [W-1:0]  out_quot;
  logic [W-1:0]  out_rem;
  logic [TW-1:0] out_tag;

  div_iter_param #(.WIDTH(W), .TAG_W(TW)) dut (
    .clock(clock), .reset_n(reset_n), .flush(flush),
    .in_ready(in_ready), .in_valid(in_valid), .in_sign(in_sign),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_ready(out_ready), .out_valid(out_valid),
    .out_quot(out_quot), .out_rem(out_rem), .out_tag(out_tag)
  );

  typedef struct {
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    int            cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   have_cur;
  int   checks;
  int   errors;
  int   cyc;
  int   rdy_mode;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(posedge clock) begin
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(0, 2) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: RISC-V division semantics from plain integer arithmetic.
  function automatic void model(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r);
    int sa;
    int sb;
    if (b == '0) begin
      q = '1;
      r = a;
    end else if (s) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Monitor: pop the expectation on first sight of a result, then hold it until the handshake.
  always @(negedge clock) begin
    if (reset_n && out_valid && !flush) begin
      if (!have_cur) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_out_valid actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          cur      = exp_q.pop_front();
          have_cur = 1'b1;
          check("latency", 32'(cyc), 32'(cur.cyc));
        end
      end
      if (have_cur) begin
        check("quot", 32'(out_quot), 32'(cur.q));
        check("rem", 32'(out_rem), 32'(cur.r));
        check("tag", 32'(out_tag), 32'(cur.tag));
        check("in_ready_in_hold", 32'(in_ready), 32'(0));
        if (out_ready) have_cur = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Called at posedge+1: drives one cycle of inputs and records what the DUT will do with them.
  task automatic drive(input logic v, input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t, input logic f, output bit accepted);
    exp_t e;
    bit   special;
    in_valid = v;
    in_sign  = s;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
    flush    = f;
    accepted = 1'b0;
    if (f && !in_ready) begin
      exp_q.delete();
      have_cur = 1'b0;
    end
    if (v && !f && in_ready) begin
      model(s, a, b, e.q, e.r);
      special  = (b == '0) || (s && a == 8'h80 && b == 8'hFF);
      e.tag    = t;
      e.cyc    = cyc + ((BYP && special) ? 1 : int'(W) + 1);
      exp_q.push_back(e);
      accepted = 1'b1;
    end
  endtask

  task automatic do_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] t);
    bit acc;
    for (int i = 0; i < 200 && !in_ready; i++) step();
    drive(1'b1, s, a, b, t, 1'b0, acc);
    check("op_accepted", 32'(acc), 32'(1));
    step();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
  endtask

  task automatic wait_idle(input string name);
    bit acc;
    bit idle;
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
    idle = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !have_cur && in_ready) begin
        idle = 1'b1;
        break;
      end
      step();
    end
    check(name, 32'(idle), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int accepted_n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    have_cur  = 1'b0;
    rdy_mode  = 0;
    reset_n   = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_sign   = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b1;
    repeat (3) step();
    check("rst_in_ready", 32'(in_ready), 32'(1));
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_quot", 32'(out_quot), 32'(0));
    check("rst_rem", 32'(out_rem), 32'(0));
    check("rst_tag", 32'(out_tag), 32'(0));
    reset_n = 1'b1;
    step();

    // Directed corner cases.
    do_op(1'b0, 8'd100, 8'd7, 2'd3);  wait_idle("idle_u100_7");
    do_op(1'b1, 8'hF9, 8'h02, 2'd0);  wait_idle("idle_sm7_2");
    do_op(1'b1, 8'h07, 8'hFE, 2'd1);  wait_idle("idle_s7_m2");
    do_op(1'b1, 8'h80, 8'hFF, 2'd2);  wait_idle("idle_sovf");
    do_op(1'b1, 8'hFB, 8'h00, 2'd3);  wait_idle("idle_sdiv0");
    do_op(1'b0, 8'hC8, 8'h00, 2'd1);  wait_idle("idle_udiv0");
    do_op(1'b0, 8'hFF, 8'h01, 2'd2);  wait_idle("idle_u255_1");

    // Flush mid-RUN drops the op; the unit is ready again on the next cycle.
    do_op(1'b0, 8'd50, 8'd3, 2'd2);
    repeat (3) step();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1, acc);
    step();
    drive(1'b0, 1'b0, '0, '0, '0, 1'b0, acc);
    check("flush_in_ready", 32'(in_ready), 32'(1));
    check("flush_out_valid", 32'(out_valid), 32'(0));
    repeat (12) step();
    check("flush_no_result", 32'(out_valid), 32'(0));
    do_op(1'b0, 8'd9, 8'd3, 2'd1);  wait_idle("idle_after_flush");

    // Consumer stalls for 20 cycles while the result is held.
    rdy_mode = 2;
    do_op(1'b0, 8'd200, 8'd13, 2'd1);
    for (int i = 0; i < 50 && !out_valid; i++) step();
    repeat (20) step();
    check("stall_out_valid", 32'(out_valid), 32'(1));
    rdy_mode = 0;
    wait_idle("idle_after_stall");

    // Asynchronous reset mid-RUN.
    do_op(1'b1, 8'h85, 8'h03, 2'd2);
    repeat (3) step();
    reset_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'(0));
    check("midrst_in_ready", 32'(in_ready), 32'(1));
    exp_q.delete();
    have_cur = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    check("midrst_quot", 32'(out_quot), 32'(0));
    do_op(1'b0, 8'd9, 8'd3, 2'd3);  wait_idle("idle_after_reset");

    // Random traffic with random flushes and backpressure.
    rdy_mode   = 1;
    accepted_n = 0;
    for (int c = 0; c < 40000 && accepted_n < 1000; c++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      case ($urandom_range(0, 9))
        0: rb = '0;
        1: rb = '1;
        2: begin ra = 8'h80; rb = '1; end
        3: rb = W'($urandom_range(1, 3));
        default: ;
      endcase
      drive($urandom_range(0, 3) != 0, W'($urandom_range(0, 1)) != 0, ra, rb,
            TW'($urandom), $urandom_range(0, 24) == 0, acc);
      if (acc) accepted_n++;
      step();
    end
    check("random_ops_accepted", 32'(accepted_n >= 1000), 32'(1));
    rdy_mode = 0;
    wait_idle("idle_after_random");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
